uart_tx_switch: RTL and testbench

UART_TX_SWITCH -- requirements
Module: uart_tx_switch

---
 rtl/uart_tx_switch.sv | 124 ++++++++++++
 tb/tb_uart_tx_switch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_switch.sv
// Hands the TXD pad between the CPU UART and the debug coprocessor UART.
// Ownership changes only while the line is idle, or when a pending request has waited too long.
module uart_tx_switch #(
    parameter int BAUD_PERIOD = 108,
    parameter int IDLE_BITS   = 2,
    parameter int WAIT_LIMIT  = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic sel_ocd1_cpu0,
    input  logic tx_cpu,
    input  logic tx_ocd,
    output logic TXD,
    output logic active_ocd1_cpu0,
    output logic switch_pending
);

    localparam int IDLE_CYCLES = BAUD_PERIOD * IDLE_BITS;
    localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);
    localparam int WAIT_W      = $clog2(WAIT_LIMIT + 1);

    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_FORCE = WAIT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        WAIT_OCD = 2'd1,
        OWN_OCD  = 2'd2,
        WAIT_CPU = 2'd3
    } state_t;

    state_t            r_state;
    logic [IDLE_W-1:0] r_idleCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_txd;
    logic              r_active;
    logic              r_pending;

    logic              w_ownerIsOcd;
    logic              w_ownerLine;
    logic              w_idleFull;
    logic              w_waitForce;
    logic [IDLE_W-1:0] w_idleNext;
    logic [WAIT_W-1:0] w_waitNext;

    assign w_ownerIsOcd = (r_state == OWN_OCD) || (r_state == WAIT_CPU);
    assign w_ownerLine  = w_ownerIsOcd ? tx_ocd : tx_cpu;
    assign w_idleFull   = (r_idleCnt == IDLE_MAX);
    assign w_waitForce  = (r_waitCnt == WAIT_FORCE);

    // Idle run length of the owner's line; any low bit restarts the measurement.
    assign w_idleNext = !w_ownerLine ? '0 :
                        (w_idleFull ? r_idleCnt : r_idleCnt + 1'b1);
    assign w_waitNext = (r_waitCnt == WAIT_MAX) ? r_waitCnt : r_waitCnt + 1'b1;

    // TXD is sampled from the owner as selected before the edge, so a new owner's
    // first bit reaches the pad exactly one cycle after the state changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= OWN_CPU;
            r_idleCnt <= '0;
            r_waitCnt <= '0;
            r_txd     <= 1'b1;
            r_active  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_txd     <= w_ownerLine;
            r_idleCnt <= w_idleNext;
            case (r_state)
                OWN_CPU: begin
                    if (sel_ocd1_cpu0) begin
                        r_state   <= WAIT_OCD;
                        r_pending <= 1'b1;
                        r_waitCnt <= '0;
                    end
                end
                WAIT_OCD: begin
                    if (!sel_ocd1_cpu0) begin
                        r_state   <= OWN_CPU;
                        r_pending <= 1'b0;
                    end else if ((w_idleFull && tx_ocd) || w_waitForce) begin
                        r_state   <= OWN_OCD;
                        r_active  <= 1'b1;
                        r_pending <= 1'b0;
                        r_idleCnt <= '0;
                    end else begin
                        r_waitCnt <= w_waitNext;
                    end
                end
                OWN_OCD: begin
                    if (!sel_ocd1_cpu0) begin
                        r_state   <= WAIT_CPU;
                        r_pending <= 1'b1;
                        r_waitCnt <= '0;
                    end
                end
                WAIT_CPU: begin
                    if (sel_ocd1_cpu0) begin
                        r_state   <= OWN_OCD;
                        r_pending <= 1'b0;
                    end else if ((w_idleFull && tx_cpu) || w_waitForce) begin
                        r_state   <= OWN_CPU;
                        r_active  <= 1'b0;
                        r_pending <= 1'b0;
                        r_idleCnt <= '0;
                    end else begin
                        r_waitCnt <= w_waitNext;
                    end
                end
                default: begin
                    r_state   <= OWN_CPU;
                    r_active  <= 1'b0;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign TXD              = r_txd;
    assign active_ocd1_cpu0 = r_active;
    assign switch_pending   = r_pending;

endmodule

// File: tb/tb_uart_tx_switch.sv
// Directed bench for uart_tx_switch with BAUD_PERIOD=4, IDLE_BITS=2, WAIT_LIMIT=64.
// Expected values are hand-derived cycle counts from the request edge.
module tb_uart_tx_switch;

    logic clk;
    logic reset;
    logic sel;
    logic txCpu;
    logic txOcd;
    logic txd;
    logic active;
    logic pending;

    int   errorCount;
    int   checkCount;
    int   framePos;
    logic frameMode;
    logic prevCpu;
    logic [9:0] frameBits;

    uart_tx_switch #(
        .BAUD_PERIOD(4),
        .IDLE_BITS(2),
        .WAIT_LIMIT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sel_ocd1_cpu0(sel),
        .tx_cpu(txCpu),
        .tx_ocd(txOcd),
        .TXD(txd),
        .active_ocd1_cpu0(active),
        .switch_pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advances n clock edges; in frame mode the CPU line replays 0x55 frames with no gap after the stop bit.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            if (frameMode) begin
                txCpu = frameBits[(framePos / 4) % 10];
                framePos++;
            end
            prevCpu = txCpu;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        framePos   = 0;
        frameMode  = 1'b0;
        frameBits  = {1'b1, 8'h55, 1'b0};
        prevCpu    = 1'b0;
        reset      = 1'b0;
        sel        = 1'b0;
        txCpu      = 1'b0;
        txOcd      = 1'b1;

        // Reset state, then the first edge after release loads tx_cpu=0
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_active", active, 0);
        checkOutput("reset_pending", pending, 0);
        reset = 1'b0;
        #2;
        checkOutput("release_txd_before_edge", txd, 1);
        applyStimulus(1);
        checkOutput("release_txd_after_edge", txd, 0);
        checkOutput("release_active", active, 0);
        checkOutput("release_pending", pending, 0);

        // Idle already satisfied: one cycle of WAIT, then switch
        txCpu = 1'b1;
        txOcd = 1'b1;
        applyStimulus(20);
        checkOutput("idle_active_before", active, 0);
        sel = 1'b1;
        applyStimulus(1);
        checkOutput("fast_pending", pending, 1);
        checkOutput("fast_active_wait", active, 0);
        applyStimulus(1);
        checkOutput("fast_active", active, 1);
        checkOutput("fast_pending_clear", pending, 0);
        txOcd = 1'b0;
        applyStimulus(1);
        checkOutput("fast_txd_follows_ocd0", txd, 0);
        txOcd = 1'b1;
        txCpu = 1'b0;
        applyStimulus(1);
        checkOutput("fast_txd_follows_ocd1", txd, 1);

        // Busy CPU line: switch forced after 64 cycles
        sel = 1'b0;
        applyReset();
        txOcd     = 1'b1;
        framePos  = 0;
        frameMode = 1'b1;
        applyStimulus(20);
        sel = 1'b1;
        applyStimulus(1);
        checkOutput("force_pending_start", pending, 1);
        for (int i = 1; i < 64; i++) begin
            applyStimulus(1);
            checkOutput("force_txd_cpu", txd, prevCpu);
            if (i == 63) begin
                checkOutput("force_active_63", active, 0);
                checkOutput("force_pending_63", pending, 1);
            end
        end
        applyStimulus(1);
        checkOutput("force_active_64", active, 1);
        checkOutput("force_pending_64", pending, 0);
        frameMode = 1'b0;

        // Request reverted mid-frame: no switch, CPU bits intact
        sel = 1'b0;
        applyReset();
        framePos  = 0;
        frameMode = 1'b1;
        applyStimulus(10);
        sel = 1'b1;
        applyStimulus(1);
        checkOutput("revert_pending", pending, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("revert_txd_wait", txd, prevCpu);
        end
        sel = 1'b0;
        applyStimulus(1);
        checkOutput("revert_pending_clear", pending, 0);
        checkOutput("revert_active", active, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1);
            checkOutput("revert_txd_after", txd, prevCpu);
            checkOutput("revert_active_after", active, 0);
        end
        frameMode = 1'b0;

        // Idle count satisfied but OCD mid-frame: waits for tx_ocd high
        applyReset();
        txCpu = 1'b1;
        txOcd = 1'b0;
        applyStimulus(10);
        sel = 1'b1;
        applyStimulus(1);
        checkOutput("ocdlow_pending", pending, 1);
        applyStimulus(3);
        checkOutput("ocdlow_no_switch", active, 0);
        checkOutput("ocdlow_still_pending", pending, 1);
        txOcd = 1'b1;
        applyStimulus(1);
        checkOutput("ocdlow_switch", active, 1);
        checkOutput("ocdlow_pending_clear", pending, 0);

        // Reset during WAIT_CPU acts without a clock edge
        sel = 1'b0;
        txOcd = 1'b0;
        applyStimulus(1);
        checkOutput("waitcpu_pending", pending, 1);
        checkOutput("waitcpu_active", active, 1);
        applyStimulus(9);
        checkOutput("waitcpu_txd", txd, 0);
        checkOutput("waitcpu_pending_10", pending, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_txd", txd, 1);
        checkOutput("async_reset_active", active, 0);
        checkOutput("async_reset_pending", pending, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        txCpu = 1'b0;
        txOcd = 1'b1;
        applyStimulus(1);
        checkOutput("post_reset_txd_cpu", txd, 0);
        checkOutput("post_reset_active", active, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
